// File: rtl/obstacle_alert_arbiter.sv
// Per-channel sensor synchroniser and debouncer feeding a fixed-priority or round-robin
// arbiter that drives a one-hot warning vector with a guaranteed minimum on-time.
module obstacle_alert_arbiter #(
    parameter  int N_SENSORS = 3,
    parameter  int DEBOUNCE  = 4,
    parameter  int HOLD      = 8,
    localparam int IDXW      = $clog2(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena_i,
    input  logic [N_SENSORS-1:0] sensor_i,
    input  logic                 mode_i,
    output logic [N_SENSORS-1:0] warn_o,
    output logic [IDXW-1:0]      warn_idx_o,
    output logic                 any_warn_o
);
    // state | meaning
    // IDLE  | no warning driven; cur kept as round-robin pointer
    // ALERT | warning on channel cur; hold counts down the minimum on-time
    typedef enum logic {IDLE, ALERT} state_t;

    localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    logic [N_SENSORS-1:0] s1_q, s2_q, db_q;
    logic [3:0]           cnt_q [N_SENSORS];
    state_t               state_q, state_d;
    logic [IDXW-1:0]      cur_q, cur_d;
    logic [7:0]           hold_q, hold_d;
    logic [IDXW-1:0]      low_idx, rr_idx, pick;
    logic                 hi_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            db_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) cnt_q[i] <= '0;
        end else begin
            s1_q <= sensor_i;
            s2_q <= s1_q;
            for (int i = 0; i < N_SENSORS; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    db_q[i]  <= s2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // Round-robin: first set index above cur, else wrap to the lowest set index (may be cur).
    always_comb begin
        low_idx  = '0;
        rr_idx   = '0;
        hi_found = 1'b0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (db_q[i]) low_idx = IDXW'(i);
        end
        rr_idx = low_idx;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (!hi_found && db_q[i] && (IDXW'(i) > cur_q)) begin
                rr_idx   = IDXW'(i);
                hi_found = 1'b1;
            end
        end
        pick = mode_i ? rr_idx : low_idx;
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hold_d  = hold_q;
        if (!ena_i) begin
            state_d = IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|db_q) begin
                        state_d = ALERT;
                        cur_d   = pick;
                        hold_d  = HOLD_LAST;
                    end
                end
                ALERT: begin
                    if (hold_q != '0) begin
                        if (!mode_i && (|db_q) && (low_idx < cur_q)) begin
                            cur_d  = low_idx;
                            hold_d = HOLD_LAST;
                        end else begin
                            hold_d = hold_q - 8'd1;
                        end
                    end else if (db_q == '0) begin
                        state_d = IDLE;
                    end else if (pick != cur_q) begin
                        cur_d  = pick;
                        hold_d = HOLD_LAST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        warn_o = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            warn_o[i] = (state_q == ALERT) && (cur_q == IDXW'(i));
        end
        warn_idx_o = (state_q == ALERT) ? cur_q : '0;
        any_warn_o = (state_q == ALERT);
    end
endmodule

// File: tb/tb_obstacle_alert_arbiter.sv
// Directed bench for obstacle_alert_arbiter: a per-cycle behavioural model plus
// hand-computed literal expectations at the key edges.
module tb_obstacle_alert_arbiter;
    localparam int N  = 3;
    localparam int DB = 4;
    localparam int HD = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic [N-1:0] sensor = '0;
    logic         mode = 1'b0;
    logic [N-1:0] warn;
    logic [1:0]   warn_idx;
    logic         any_warn;

    int checks = 0;
    int failures = 0;

    obstacle_alert_arbiter #(.N_SENSORS(N), .DEBOUNCE(DB), .HOLD(HD)) dut (
        .clk(clk), .rst_n(rst_n), .ena_i(ena), .sensor_i(sensor), .mode_i(mode),
        .warn_o(warn), .warn_idx_o(warn_idx), .any_warn_o(any_warn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer levels, run-length debounce, channel/hold bookkeeping.
    int  m_s1[N], m_s2[N], m_db[N], m_run[N];
    bit  m_on;
    int  m_cur, m_hold;
    bit  seen_reset = 0;

    always @(posedge clk) begin
        int low, rr, pick, idx;
        logic [N-1:0] ew;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
            end
            m_on = 0; m_cur = 0; m_hold = 0;
            seen_reset = 1;
        end else begin
            low = -1;
            for (int i = N - 1; i >= 0; i--) if (m_db[i] != 0) low = i;
            rr = -1;
            for (int k = N; k >= 1; k--) begin
                idx = (m_cur + k) % N;
                if (m_db[idx] != 0) rr = idx;
            end
            pick = mode ? rr : low;
            if (!ena) begin
                m_on = 0; m_hold = 0;
            end else if (!m_on) begin
                if (low >= 0) begin m_on = 1; m_cur = pick; m_hold = HD - 1; end
            end else if (m_hold > 0) begin
                if (!mode && low >= 0 && low < m_cur) begin m_cur = low; m_hold = HD - 1; end
                else m_hold = m_hold - 1;
            end else if (low < 0) begin
                m_on = 0;
            end else if (pick != m_cur) begin
                m_cur = pick; m_hold = HD - 1;
            end
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(sensor[i]);
            end
        end
        #1;
        if (seen_reset) begin
            ew = '0;
            if (m_on) ew[m_cur] = 1'b1;
            chk("model_warn", int'(warn), int'(ew));
            chk("model_idx", int'(warn_idx), m_on ? m_cur : 0);
            chk("model_any", int'(any_warn), int'(m_on));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sensor = '0; mode = 1'b0; ena = 1'b1;
        edges(2);
        rst_n = 1'b1;
    endtask

    task automatic lit(input string name, input int w, input int idx);
        chk({name, "_warn"}, int'(warn), w);
        chk({name, "_idx"}, int'(warn_idx), idx);
        chk({name, "_any"}, int'(any_warn), int'(w != 0));
    endtask

    initial begin
        int waited;
        // Reset held with all sensors high.
        rst_n = 1'b0; sensor = 3'b111;
        edges(3);
        lit("reset", 0, 0);
        rst_n = 1'b1;
        edges(6);
        lit("reset_rel_e5", 0, 0);
        edges(1);
        lit("reset_rel_e6", 1, 0);

        // Assert latency and glitch rejection.
        do_reset();
        sensor = 3'b010;
        edges(6);
        lit("assert_e5", 0, 0);
        edges(1);
        lit("assert_e6", 2, 1);
        sensor = 3'b110;
        edges(3);
        sensor = 3'b010;
        edges(8);
        lit("glitch", 2, 1);

        // Minimum hold on a 5-cycle pulse.
        do_reset();
        sensor = 3'b001;
        edges(5);
        sensor = 3'b000;
        edges(1);
        lit("hold_e5", 0, 0);
        edges(1);
        lit("hold_e6", 1, 0);
        edges(7);
        lit("hold_e13", 1, 0);
        edges(1);
        lit("hold_e14", 0, 0);

        // Preemption while the hold is still running.
        do_reset();
        sensor = 3'b100;
        edges(2);
        sensor = 3'b101;
        edges(5);
        lit("pre_e6", 4, 2);
        edges(1);
        lit("pre_e7", 4, 2);
        edges(1);
        lit("pre_e8", 1, 0);

        // Late higher-priority arrival.
        do_reset();
        sensor = 3'b100;
        edges(9);
        sensor = 3'b101;
        edges(6);
        lit("late_e14", 4, 2);
        edges(1);
        lit("late_e15", 1, 0);

        // Round-robin: park pointer on channel 2 first, then all sensors high.
        do_reset();
        sensor = 3'b100;
        edges(7);
        lit("rr_setup", 4, 2);
        sensor = 3'b000;
        edges(14);
        lit("rr_idle", 0, 0);
        mode = 1'b1; sensor = 3'b111;
        waited = 0;
        while (warn != 3'b001 && waited < 20) begin
            edges(1);
            waited++;
        end
        chk("rr_first_wait", int'(waited < 20), 1);
        edges(7);
        lit("rr_0_end", 1, 0);
        edges(1);
        lit("rr_1", 2, 1);
        edges(7);
        lit("rr_1_end", 2, 1);
        edges(1);
        lit("rr_2", 4, 2);
        edges(8);
        lit("rr_0_again", 1, 0);
        mode = 1'b0;
        edges(7);
        lit("fix_hold_end", 1, 0);
        edges(1);
        lit("fix_stay", 1, 0);
        edges(8);
        lit("fix_stay2", 1, 0);

        // Mid-alert enable and reset.
        do_reset();
        sensor = 3'b010;
        edges(7);
        lit("ena_pre", 2, 1);
        ena = 1'b0;
        edges(1);
        lit("ena_off", 0, 0);
        edges(2);
        lit("ena_off2", 0, 0);
        ena = 1'b1;
        edges(1);
        lit("ena_on", 2, 1);
        rst_n = 1'b0;
        edges(1);
        lit("rst_mid", 0, 0);
        rst_n = 1'b1;
        edges(6);
        lit("rst_rel_e5", 0, 0);
        edges(1);
        lit("rst_rel_e6", 2, 1);

        edges(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
